// File: rtl/input_window_buffer.sv
// input_window_buffer: circular input window with valid/ready writes, random offset reads and head pops; INPUT_WINDOW_BUFFER_PARITY_EN adds per-word even parity
module input_window_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_oob,
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
  output logic              rd_perr,
`endif
  input  logic              pop,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              err
);
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [MW-1:0] wr_word, rd_word;
  logic wr_acc, pop_eff, rd_hit, perr;
  assign full = count == CAP;
  assign empty = count == '0;
  assign wr_ready = !full;
  assign wr_acc = wr_valid && wr_ready;
  assign pop_eff = pop && !empty;
  assign rd_hit = rd_en && ({1'b0, rd_offset} < count);
  assign rd_word = mem[head + rd_offset];
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
  assign perr = ^rd_word;
`else
  assign wr_word = wr_data;
  assign perr = 1'b0;
`endif
  // storage is not reset; only committed words are ever read
  always_ff @(posedge clk)
    if (wr_acc) mem[tail] <= wr_word;
  // pointers, occupancy, registered read result and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_oob <= 1'b0;
      err <= 1'b0;
    end else begin
      if (wr_acc) tail <= tail + AW'(1);
      if (pop_eff) head <= head + AW'(1);
      count <= count + (AW+1)'(wr_acc) - (AW+1)'(pop_eff);
      if (rd_hit) rd_data <= rd_word[DATA_W-1:0];
      rd_valid <= rd_hit;
      rd_oob <= rd_en && !rd_hit;
      err <= err | (pop && empty) | (rd_en && !rd_hit) | (rd_hit && perr);
    end
  end
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
  // parity flag travels with the read result
  always_ff @(posedge clk)
    rd_perr <= rst ? 1'b0 : rd_hit && perr;
`endif
endmodule

// File: tb/tb_input_window_buffer.sv
// tb_input_window_buffer: table-driven and directed checks of the input window buffer
module tb_input_window_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [7:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic [5:0] rd_offset = '0;
  logic [7:0] rd_data;
  logic rd_valid, rd_oob;
  logic pop = 1'b0;
  logic [6:0] count;
  logic full, empty, err;
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
  logic rd_perr;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_window_buffer #(.DATA_W(8), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_en(rd_en), .rd_offset(rd_offset), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_oob(rd_oob),
`ifdef INPUT_WINDOW_BUFFER_PARITY_EN
    .rd_perr(rd_perr),
`endif
    .pop(pop), .count(count), .full(full), .empty(empty), .err(err)
  );

  typedef struct {
    logic wv; logic [7:0] wd; logic re; logic [5:0] ro; logic pp;
    int cnt; logic rv; logic [7:0] rd; logic oob; logic er; logic fu;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic re,
                      input logic [5:0] ro, input logic pp);
    wr_valid = wv; wr_data = wd; rd_en = re; rd_offset = ro; pop = pp;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b1, 6'd5,  1'b0, 64, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 6'd0,  1'b1, 63, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 6'd0,  1'b1, 62, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 6'd0,  1'b1, 61, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 6'd0,  1'b0, 61, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 6'd60, 1'b0, 61, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'hA0, 1'b1, 6'd1,  1'b1, 61, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 6'd60, 1'b0, 61, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 6'd0,  1'b0, 61, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0};

    // reset state
    idle();
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_oob", int'(rd_oob), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_err", int'(err), 0);

    // pop while empty is ignored but flagged
    step(1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
    chk("empty_pop_err", int'(err), 1);
    chk("empty_pop_count", int'(count), 0);
    chk("empty_pop_empty", int'(empty), 1);

    // fill with 0x00..0x3F
    do_reset();
    for (int i = 0; i < 64; i++) begin
      chk("fill_ready", int'(wr_ready), 1);
      step(1'b1, 8'(i), 1'b0, 6'd0, 1'b0);
    end
    chk("fill_count", int'(count), 64);
    chk("fill_full", int'(full), 1);
    chk("fill_ready_low", int'(wr_ready), 0);
    step(1'b1, 8'hFF, 1'b0, 6'd0, 1'b0);
    chk("overfill_count", int'(count), 64);
    chk("overfill_err", int'(err), 0);

    // table-driven reads, pops and wrap
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].re, tbl[i].ro, tbl[i].pp);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].cnt);
      chk($sformatf("v%0d_rd_valid", i), int'(rd_valid), int'(tbl[i].rv));
      chk($sformatf("v%0d_rd_data", i), int'(rd_data), int'(tbl[i].rd));
      chk($sformatf("v%0d_rd_oob", i), int'(rd_oob), int'(tbl[i].oob));
      chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].er));
      chk($sformatf("v%0d_full", i), int'(full), int'(tbl[i].fu));
    end

    // head to 10, then refill with 0xA1..0xA9 so tail reaches 10
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 6'd0, 1'b1);
    chk("wrap_pop_count", int'(count), 55);
    for (int i = 1; i < 10; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 6'd0, 1'b0);
    chk("wrap_count", int'(count), 64);
    chk("wrap_full", int'(full), 1);
    step(1'b0, 8'h00, 1'b1, 6'd63, 1'b0);
    chk("wrap_rd_valid", int'(rd_valid), 1);
    chk("wrap_rd_data", int'(rd_data), 8'hA9);

    // write + pop while full: write refused, ready returns next cycle
    chk("full_ready_before", int'(wr_ready), 0);
    step(1'b1, 8'hBB, 1'b0, 6'd0, 1'b1);
    chk("full_wp_count", int'(count), 63);
    chk("full_wp_ready", int'(wr_ready), 1);
    step(1'b0, 8'h00, 1'b1, 6'd62, 1'b0);
    chk("full_wp_last", int'(rd_data), 8'hA9);
    step(1'b1, 8'hCC, 1'b0, 6'd0, 1'b1);
    chk("wp_count", int'(count), 63);
    step(1'b0, 8'h00, 1'b1, 6'd62, 1'b0);
    chk("wp_last", int'(rd_data), 8'hCC);
    chk("wp_err", int'(err), 0);

    // out-of-range read with two words held
    do_reset();
    step(1'b1, 8'h11, 1'b0, 6'd0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 6'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 6'd1, 1'b0);
    chk("two_rd_data", int'(rd_data), 8'h22);
    step(1'b0, 8'h00, 1'b1, 6'd2, 1'b0);
    chk("oob_pulse", int'(rd_oob), 1);
    chk("oob_rd_valid", int'(rd_valid), 0);
    chk("oob_rd_data", int'(rd_data), 8'h22);
    chk("oob_err", int'(err), 1);
    idle();
    chk("oob_clear", int'(rd_oob), 0);
    chk("oob_err_sticky", int'(err), 1);

    // reset mid-operation with a read in flight
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 6'd0, 1'b0);
    chk("mid_count", int'(count), 20);
    step(1'b0, 8'h00, 1'b1, 6'd25, 1'b0);
    chk("mid_err_set", int'(err), 1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b1, 6'd3, 1'b0);
    rst = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_rd_valid", int'(rd_valid), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_rd_data", int'(rd_data), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
